// File: rtl/spart_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | spart_fifo_pkg : register map, status bit indices and FSM states    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package spart_fifo_pkg;

   localparam logic [1:0] ADDR_DATA = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   localparam int ST_RDA      = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_FULL  = 2;
   localparam int ST_TX_EMPTY = 3;
   localparam int ST_FRM_ERR  = 4;
   localparam int ST_PAR_ERR  = 5;
   localparam int ST_RX_OVR   = 6;
   localparam int ST_TX_OVF   = 7;

   localparam int CTRL_PAR_EN  = 0;
   localparam int CTRL_PAR_ODD = 1;
   localparam int CTRL_CLR     = 7;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/spart_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | spart_sync_fifo : show-ahead synchronous FIFO, push+pop when full   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      count_q;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is accepted only when the head leaves on the same edge
   assign w_push = push_i & (~full_o | pop_i);
   assign w_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (w_push) wptr_q <= wptr_q + 1'b1;
         if (w_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/spart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | spart_fifo : UART with CPU bus, baud divisor, parity, TX/RX FIFOs   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spart_fifo
   import spart_fifo_pkg::*;
#(
   parameter int          DATA_BITS   = 8,
   parameter int          TX_DEPTH    = 16,
   parameter int          RX_DEPTH    = 16,
   parameter int          OVS         = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd326
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);
   localparam int              OW        = $clog2(OVS);
   localparam int              BW        = $clog2(DATA_BITS);
   localparam logic [OW-1:0]   OVS_LAST  = OW'(OVS - 1);
   localparam logic [OW-1:0]   OVS_HALF  = OW'(OVS / 2 - 1);
   localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);

   logic [15:0] div_q, baud_cnt_q, baud_cnt_d, w_div_eff;
   logic [1:0]  ctrl_q;
   logic        tx_ovf_q, rx_ovr_q, par_err_q, frm_err_q;
   logic        tx_ovf_d, rx_ovr_d, par_err_d, frm_err_d;
   logic        w_tick, w_rd, w_wr, w_tx_push, w_rx_pop, w_ctrl_wr, w_clr;
   logic [7:0]  w_rdata, w_status;

   logic [DATA_BITS-1:0]     w_tx_head, w_rx_head;
   logic                     w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [$clog2(TX_DEPTH):0] w_tx_count;
   logic [$clog2(RX_DEPTH):0] w_rx_count;
   logic                     w_tx_pop, w_rx_push, w_par_evt, w_frm_evt;

   tx_state_e            tx_state_q, tx_state_d;
   logic [OW-1:0]        tx_ovs_q, tx_ovs_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
   logic                 w_tx_end;

   rx_state_e            rx_state_q, rx_state_d;
   logic [OW-1:0]        rx_ovs_q, rx_ovs_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
   logic                 rxd_meta_q, rxd_sync_q;
   logic                 w_rx_end, w_rx_half;

   // ---------------- CPU bus ----------------
   assign w_rd      = iocs & iorw;
   assign w_wr      = iocs & ~iorw;
   assign w_tx_push = w_wr & (ioaddr == ADDR_DATA);
   assign w_rx_pop  = w_rd & (ioaddr == ADDR_DATA) & ~w_rx_empty;
   assign w_ctrl_wr = w_wr & (ioaddr == ADDR_STAT);
   assign w_clr     = w_ctrl_wr & databus[CTRL_CLR];

   always_comb begin
      w_status              = '0;
      w_status[ST_TX_OVF]   = tx_ovf_q;
      w_status[ST_RX_OVR]   = rx_ovr_q;
      w_status[ST_PAR_ERR]  = par_err_q;
      w_status[ST_FRM_ERR]  = frm_err_q;
      w_status[ST_TX_EMPTY] = w_tx_empty;
      w_status[ST_TX_FULL]  = w_tx_full;
      w_status[ST_RX_FULL]  = w_rx_full;
      w_status[ST_RDA]      = ~w_rx_empty;
   end

   always_comb begin
      w_rdata = '0;
      case (ioaddr)
         ADDR_DATA: if (!w_rx_empty) w_rdata[DATA_BITS-1:0] = w_rx_head;
         ADDR_STAT: w_rdata = w_status;
         ADDR_DBL:  w_rdata = div_q[7:0];
         ADDR_DBH:  w_rdata = div_q[15:8];
         default:   w_rdata = '0;
      endcase
   end

   assign databus = w_rd ? w_rdata : 8'hzz;
   assign rda     = (w_rx_count != '0);
   assign tbr     = (w_tx_count != ($clog2(TX_DEPTH)+1)'(TX_DEPTH));

   // ---------------- Baud tick and control registers ----------------
   assign w_div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
   assign w_tick     = (baud_cnt_q == 16'd0);
   assign baud_cnt_d = w_tick ? (w_div_eff - 16'd1) : (baud_cnt_q - 16'd1);

   // A new error event in the same cycle as a clear leaves the flag set
   assign tx_ovf_d  = (tx_ovf_q  & ~w_clr) | (w_tx_push & w_tx_full & ~w_tx_pop);
   assign rx_ovr_d  = (rx_ovr_q  & ~w_clr) | (w_rx_push & w_rx_full & ~w_rx_pop);
   assign par_err_d = (par_err_q & ~w_clr) | w_par_evt;
   assign frm_err_d = (frm_err_q & ~w_clr) | w_frm_evt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= DEFAULT_DIV;
         ctrl_q     <= '0;
         baud_cnt_q <= '0;
         tx_ovf_q   <= 1'b0;
         rx_ovr_q   <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_ovr_q   <= rx_ovr_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         if (w_ctrl_wr) ctrl_q <= databus[1:0];
         if (w_wr && ioaddr == ADDR_DBL) div_q[7:0]  <= databus;
         if (w_wr && ioaddr == ADDR_DBH) div_q[15:8] <= databus;
      end
   end

   // ---------------- FIFOs ----------------
   spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst),
      .push_i(w_tx_push), .wdata_i(databus[DATA_BITS-1:0]), .pop_i(w_tx_pop),
      .rdata_o(w_tx_head), .full_o(w_tx_full), .empty_o(w_tx_empty), .count_o(w_tx_count)
   );

   spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst),
      .push_i(w_rx_push), .wdata_i(rx_shift_q), .pop_i(w_rx_pop),
      .rdata_o(w_rx_head), .full_o(w_rx_full), .empty_o(w_rx_empty), .count_o(w_rx_count)
   );

   // ---------------- TX engine ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q  <= TX_IDLE;
         tx_ovs_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         tx_par_en_q <= 1'b0;
         tx_par_q    <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_ovs_q    <= tx_ovs_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         tx_par_en_q <= tx_par_en_d;
         tx_par_q    <= tx_par_d;
      end
   end

   assign w_tx_end = w_tick & (tx_ovs_q == OVS_LAST);

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_ovs_d    = tx_ovs_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      tx_par_en_d = tx_par_en_q;
      tx_par_d    = tx_par_q;
      w_tx_pop    = 1'b0;
      if (w_tick && tx_state_q != TX_IDLE) tx_ovs_d = w_tx_end ? '0 : tx_ovs_q + 1'b1;
      case (tx_state_q)
         TX_IDLE:   w_tx_pop = w_tick & ~w_tx_empty;
         TX_START:  if (w_tx_end) begin
                       tx_state_d = TX_DATA;
                       tx_bit_d   = '0;
                    end
         TX_DATA:   if (w_tx_end) begin
                       tx_shift_d = tx_shift_q >> 1;
                       tx_bit_d   = tx_bit_q + 1'b1;
                       if (tx_bit_q == BIT_LAST) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
                    end
         TX_PARITY: if (w_tx_end) tx_state_d = TX_STOP;
         TX_STOP:   if (w_tx_end) begin
                       tx_state_d = TX_IDLE;
                       w_tx_pop   = ~w_tx_empty;
                    end
         default:   tx_state_d = TX_IDLE;
      endcase
      // Frame setup latches the control bits so mid-frame writes wait for the next frame
      if (w_tx_pop) begin
         tx_state_d  = TX_START;
         tx_ovs_d    = '0;
         tx_shift_d  = w_tx_head;
         tx_par_en_d = ctrl_q[CTRL_PAR_EN];
         tx_par_d    = (^w_tx_head) ^ ctrl_q[CTRL_PAR_ODD];
      end
   end

   always_comb begin
      case (tx_state_q)
         TX_START:  txd = 1'b0;
         TX_DATA:   txd = tx_shift_q[0];
         TX_PARITY: txd = tx_par_q;
         default:   txd = 1'b1;
      endcase
   end

   // ---------------- RX engine ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta_q   <= 1'b1;
         rxd_sync_q   <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_ovs_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
      end else begin
         rxd_meta_q   <= rxd;
         rxd_sync_q   <= rxd_meta_q;
         rx_state_q   <= rx_state_d;
         rx_ovs_q     <= rx_ovs_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_par_odd_q <= rx_par_odd_d;
      end
   end

   assign w_rx_end  = w_tick & (rx_ovs_q == OVS_LAST);
   assign w_rx_half = w_tick & (rx_ovs_q == OVS_HALF);

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_ovs_d     = rx_ovs_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_en_d  = rx_par_en_q;
      rx_par_odd_d = rx_par_odd_q;
      w_rx_push    = 1'b0;
      w_par_evt    = 1'b0;
      w_frm_evt    = 1'b0;
      if (w_tick && rx_state_q != RX_IDLE) rx_ovs_d = w_rx_end ? '0 : rx_ovs_q + 1'b1;
      case (rx_state_q)
         RX_IDLE:   if (w_tick && !rxd_sync_q) begin
                       rx_state_d   = RX_START;
                       rx_ovs_d     = '0;
                       rx_par_en_d  = ctrl_q[CTRL_PAR_EN];
                       rx_par_odd_d = ctrl_q[CTRL_PAR_ODD];
                    end
         // Half a bit in, the line must still be low or the edge was a glitch
         RX_START:  if (w_rx_half) begin
                       rx_ovs_d   = '0;
                       rx_bit_d   = '0;
                       rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                    end
         RX_DATA:   if (w_rx_end) begin
                       rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                       rx_bit_d   = rx_bit_q + 1'b1;
                       if (rx_bit_q == BIT_LAST) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    end
         RX_PARITY: if (w_rx_end) begin
                       w_par_evt  = rxd_sync_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                       rx_state_d = RX_STOP;
                    end
         RX_STOP:   if (w_rx_end) begin
                       w_frm_evt  = ~rxd_sync_q;
                       w_rx_push  = 1'b1;
                       rx_state_d = RX_IDLE;
                    end
         default:   rx_state_d = RX_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spart_fifo : directed self-checking bench for spart_fifo         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_spart_fifo;

   localparam logic [1:0] A_DATA = 2'b00;
   localparam logic [1:0] A_STAT = 2'b01;
   localparam logic [1:0] A_DBL  = 2'b10;
   localparam logic [1:0] A_DBH  = 2'b11;
   localparam int         BITC   = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       iocs = 1'b0;
   logic       iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic       tb_drv = 1'b0;
   logic [7:0] tb_wdata = 8'h00;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rda, tbr, txd;
   wire  [7:0] databus;
   wire        rxd_w;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   assign databus = tb_drv ? tb_wdata : 8'hzz;
   assign rxd_w   = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spart_fifo #(
      .DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16), .OVS(16), .DEFAULT_DIV(16'd326)
   ) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd_w)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_wdata = d; tb_drv = 1'b1;
      @(posedge clk);
      #1;
      iocs = 1'b0; tb_drv = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #2 d = databus;
      @(posedge clk);
      #1;
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
      logic [7:0] d;
      cpu_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sample_at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_txd_low(input int limit, output bit found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < limit) begin
         @(negedge clk);
         n++;
         if (txd === 1'b0) found = 1'b1;
      end
   endtask

   task automatic check_tx_frame(input int base, input logic [7:0] exp, input bit skip_start,
                                 input string tag);
      logic [7:0] got;
      if (!skip_start) begin
         sample_at(base + BITC/2);
         check({tag, "_start"}, {7'd0, txd}, 8'h00);
      end
      for (int j = 0; j < 8; j++) begin
         sample_at(base + BITC*(j+1) + BITC/2);
         got[j] = txd;
      end
      check({tag, "_data"}, got, exp);
      sample_at(base + BITC*9 + BITC/2);
      check({tag, "_stop"}, {7'd0, txd}, 8'h01);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                             input bit stop_bit);
      @(negedge clk);
      rxd_drv = 1'b0;
      idle(BITC);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         idle(BITC);
      end
      if (par_en) begin
         rxd_drv = par_bit;
         idle(BITC);
      end
      rxd_drv = stop_bit;
      idle(BITC);
      rxd_drv = 1'b1;
      idle(8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         found;
      int         n;
      int         c0;
      logic [7:0] d;

      idle(5);
      rst = 1'b1;
      idle(2);

      // Reset state
      check("rst_txd", {7'd0, txd}, 8'h01);
      check("rst_rda", {7'd0, rda}, 8'h00);
      check("rst_tbr", {7'd0, tbr}, 8'h01);
      read_check(A_STAT, 8'h08, "rst_status");
      read_check(A_DBL,  8'h46, "rst_div_lo");
      read_check(A_DBH,  8'h01, "rst_div_hi");

      cpu_write(A_DBH, 8'h00);
      cpu_write(A_DBL, 8'h02);
      read_check(A_DBL, 8'h02, "div_lo_written");
      idle(400);

      // Single byte, no parity
      cpu_write(A_DATA, 8'h55);
      wait_txd_low(20, found, n);
      check("t1_start_seen", {7'd0, found}, 8'h01);
      check("t1_latency_ok", {7'd0, (n <= 3)}, 8'h01);
      c0 = cyc;
      check_tx_frame(c0, 8'h55, 1'b0, "t1");
      idle(BITC);
      read_check(A_STAT, 8'h08, "t1_status");

      // TX FIFO overflow and back-to-back emission
      cpu_write(A_DATA, 8'hC3);
      wait_txd_low(20, found, n);
      check("t2_start_seen", {7'd0, found}, 8'h01);
      c0 = cyc;
      for (int i = 0; i < 16; i++) cpu_write(A_DATA, 8'h10 + 8'(i));
      check("t2_tbr_full", {7'd0, tbr}, 8'h00);
      cpu_write(A_DATA, 8'h20);
      read_check(A_STAT, 8'h84, "t2_status_ovf");
      check_tx_frame(c0, 8'hC3, 1'b1, "t2_f0");
      for (int k = 1; k <= 16; k++)
         check_tx_frame(c0 + 10*BITC*k, 8'h10 + 8'(k-1), 1'b0, $sformatf("t2_f%0d", k));
      read_check(A_STAT, 8'h88, "t2_status_done");
      idle(BITC);
      cpu_write(A_STAT, 8'h80);
      read_check(A_STAT, 8'h08, "t2_cleared");

      // Loopback with odd parity
      cpu_write(A_STAT, 8'h03);
      loop_en = 1'b1;
      cpu_write(A_DATA, 8'hA3);
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (rda === 1'b1) found = 1'b1;
      end
      check("t3_rda_seen", {7'd0, found}, 8'h01);
      read_check(A_STAT, 8'h09, "t3_status");
      read_check(A_DATA, 8'hA3, "t3_data");
      check("t3_rda_drop", {7'd0, rda}, 8'h00);
      idle(40);
      loop_en = 1'b0;
      idle(10);

      // Parity error: even parity bit while odd configured
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      idle(10);
      read_check(A_STAT, 8'h29, "t4_status_par");
      read_check(A_DATA, 8'h3C, "t4_data");
      cpu_write(A_STAT, 8'h80);
      read_check(A_STAT, 8'h08, "t4_cleared");

      // Framing error, then a short glitch
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      idle(40);
      read_check(A_STAT, 8'h19, "t5_status_frm");
      read_check(A_DATA, 8'h5A, "t5_data");
      @(negedge clk);
      rxd_drv = 1'b0;
      idle(8);
      rxd_drv = 1'b1;
      idle(BITC*12);
      check("t5_glitch_rda", {7'd0, rda}, 8'h00);
      read_check(A_STAT, 8'h18, "t5_glitch_status");
      cpu_write(A_STAT, 8'h80);

      // RX overrun
      for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
      idle(20);
      read_check(A_STAT, 8'h4B, "t6_status_ovr");
      for (int i = 0; i < 16; i++) begin
         cpu_read(A_DATA, d);
         check($sformatf("t6_rx%0d", i), d, 8'h40 + 8'(i));
      end
      read_check(A_DATA, 8'h00, "t6_empty_read");
      check("t6_rda_low", {7'd0, rda}, 8'h00);

      // Reset mid-frame
      cpu_write(A_DATA, 8'h00);
      wait_txd_low(20, found, n);
      check("t7_start_seen", {7'd0, found}, 8'h01);
      idle(40);
      rst = 1'b0;
      #1;
      check("t7_rst_txd", {7'd0, txd}, 8'h01);
      check("t7_rst_tbr", {7'd0, tbr}, 8'h01);
      idle(3);
      rst = 1'b1;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
